// File: rtl/tow_arena.sv
// Tug-of-war match engine: two players pull one lit LED, first to MAX rounds wins, optional LFSR computer.
// Latency: a button rising edge moves the field on the same clock edge; no backpressure, inputs are levels.
module tow_arena #(
  parameter int FIELD    = 9,
  parameter int SCORE_W  = 3,
  parameter int HOLD_CYC = 4,
  parameter int LFSR_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p1_btn,
  input  logic               p2_btn,
  input  logic               cpu_en,
  input  logic [LFSR_W-1:0]  cpu_level,
  output logic [FIELD-1:0]   field,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         round_win,
  output logic               match_over,
  output logic [1:0]         winner
);

  localparam int POS_W = $clog2(FIELD);
  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(FIELD - 1);
  localparam logic [POS_W-1:0]   CENTER   = POS_W'((FIELD - 1) / 2);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [SCORE_W-1:0] MAX      = {SCORE_W{1'b1}};
  localparam logic [FIELD-1:0]   ONE_BIT  = {{(FIELD - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    PLAY,
    ROUND_END,
    MATCH_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_p2_q, last_p2_d;
  logic [1:0]         round_win_q, round_win_d;
  logic               match_over_q, match_over_d;
  logic [1:0]         winner_q, winner_d;
  logic [FIELD-1:0]   field_q, field_d;
  logic               src1_q, src1_d;
  logic               src2_q, src2_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;

  logic lfsr_fb;
  logic cpu_strobe;
  logic p2_src;
  logic press1;
  logic press2;

  generate
    if ((FIELD < 3) || ((FIELD % 2) == 0)) begin : g_bad_field
      $error("tow_arena: FIELD must be odd and >= 3");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
      $error("tow_arena: HOLD_CYC must be >= 1");
    end
    if (LFSR_W == 10) begin : g_taps10
      assign lfsr_fb = ~(lfsr_q[9] ^ lfsr_q[6]);
    end else if (LFSR_W == 9) begin : g_taps9
      assign lfsr_fb = ~(lfsr_q[8] ^ lfsr_q[4]);
    end else if (LFSR_W == 8) begin : g_taps8
      assign lfsr_fb = ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]);
    end else begin : g_bad_lfsr
      $error("tow_arena: LFSR_W must be 8, 9 or 10");
      assign lfsr_fb = 1'b0;
    end
  endgenerate

  assign cpu_strobe = (lfsr_q < cpu_level);
  assign p2_src     = cpu_en ? cpu_strobe : p2_btn;
  assign press1     = p1_btn & ~src1_q;
  assign press2     = p2_src & ~src2_q;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    cnt_d        = cnt_q;
    last_p2_d    = last_p2_q;
    round_win_d  = 2'b00;
    match_over_d = match_over_q;
    winner_d     = winner_q;
    src1_d       = p1_btn;
    src2_d       = p2_src;
    lfsr_d       = {lfsr_q[LFSR_W-2:0], lfsr_fb};

    case (state_q)
      PLAY: begin
        if (press1 && !press2) begin
          if (pos_q == POS_MAX) begin
            if (score1_q != MAX) score1_d = score1_q + SCORE_W'(1);
            round_win_d = 2'b01;
            last_p2_d   = 1'b0;
            cnt_d       = '0;
            state_d     = ROUND_END;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (press2 && !press1) begin
          if (pos_q == '0) begin
            if (score2_q != MAX) score2_d = score2_q + SCORE_W'(1);
            round_win_d = 2'b10;
            last_p2_d   = 1'b1;
            cnt_d       = '0;
            state_d     = ROUND_END;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
      ROUND_END: begin
        if (cnt_q == CNT_LAST) begin
          // The round winner's score decides whether the match is finished.
          if ((last_p2_q ? score2_q : score1_q) == MAX) begin
            state_d      = MATCH_OVER;
            match_over_d = 1'b1;
            winner_d     = last_p2_q ? 2'b10 : 2'b01;
          end else begin
            state_d = PLAY;
            pos_d   = CENTER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MATCH_OVER: begin
        state_d = MATCH_OVER;
      end
      default: begin
        state_d = PLAY;
        pos_d   = CENTER;
      end
    endcase

    case (state_d)
      PLAY:       field_d = ONE_BIT << pos_d;
      ROUND_END:  field_d = '0;
      MATCH_OVER: field_d = '1;
      default:    field_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLAY;
      pos_q        <= CENTER;
      score1_q     <= '0;
      score2_q     <= '0;
      cnt_q        <= '0;
      last_p2_q    <= 1'b0;
      round_win_q  <= 2'b00;
      match_over_q <= 1'b0;
      winner_q     <= 2'b00;
      field_q      <= ONE_BIT << CENTER;
      // Held buttons must not register as a press right after reset.
      src1_q       <= 1'b1;
      src2_q       <= 1'b1;
      lfsr_q       <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      cnt_q        <= cnt_d;
      last_p2_q    <= last_p2_d;
      round_win_q  <= round_win_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
      field_q      <= field_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign field      = field_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign round_win  = round_win_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_tow_arena.sv
// Directed bench for tow_arena: the driver queues the outputs expected after each clock, a monitor compares them.
module tb_tow_arena;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1_btn = 1'b0;
  logic       p2_btn = 1'b0;
  logic       cpu_en = 1'b0;
  logic [9:0] cpu_level = 10'd0;
  logic [8:0] field;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [1:0] round_win;
  logic       match_over;
  logic [1:0] winner;

  tow_arena #(
    .FIELD(9),
    .SCORE_W(3),
    .HOLD_CYC(4),
    .LFSR_W(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .p1_btn(p1_btn),
    .p2_btn(p2_btn),
    .cpu_en(cpu_en),
    .cpu_level(cpu_level),
    .field(field),
    .score1(score1),
    .score2(score2),
    .round_win(round_win),
    .match_over(match_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [8:0] f;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [1:0] rw;
    logic       mo;
    logic [1:0] w;
  } exp_t;

  localparam logic [8:0] CTR  = 9'b000010000;
  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] ONES = 9'b111111111;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc) begin
        failures = failures + 1;
        $display("FAIL %s late: due cyc=%0d seen cyc=%0d", nm, e.cyc, cyc);
      end else if ({field, score1, score2, round_win, match_over, winner} !==
                   {e.f, e.s1, e.s2, e.rw, e.mo, e.w}) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d got f=%b s1=%0d s2=%0d rw=%b mo=%b w=%b want f=%b s1=%0d s2=%0d rw=%b mo=%b w=%b",
                 nm, cyc, field, score1, score2, round_win, match_over, winner,
                 e.f, e.s1, e.s2, e.rw, e.mo, e.w);
      end
    end
  end

  function automatic logic [8:0] oh(input int p);
    logic [8:0] one;
    one = 9'b000000001;
    return one << p;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after that clock edge.
  task automatic step(input logic r, input logic a, input logic b,
                      input logic [8:0] f, input logic [2:0] s1, input logic [2:0] s2,
                      input logic [1:0] rw, input logic mo, input logic [1:0] w,
                      input string nm);
    exp_t e;
    reset  = r;
    p1_btn = a;
    p2_btn = b;
    e.cyc = cyc + 1;
    e.f   = f;
    e.s1  = s1;
    e.s2  = s2;
    e.rw  = rw;
    e.mo  = mo;
    e.w   = w;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] m;
    logic       prev;
    logic       s;
    int         pr;

    // Button held through reset and afterwards never counts as a press.
    step(1, 1, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "reset_state");
    repeat (10) step(0, 1, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "held_no_move");
    step(0, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "release");

    // Player 1 walks to the end and takes the round.
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, oh(4 + k), 0, 0, 2'b00, 0, 2'b00, "p1_move");
      step(0, 0, 0, oh(4 + k), 0, 0, 2'b00, 0, 2'b00, "p1_gap");
    end
    step(0, 1, 0, ZERO, 1, 0, 2'b01, 0, 2'b00, "p1_round_win");
    repeat (3) step(0, 1, 0, ZERO, 1, 0, 2'b00, 0, 2'b00, "round_end_hold");
    step(0, 0, 0, CTR, 1, 0, 2'b00, 0, 2'b00, "next_round");

    // Simultaneous presses cancel; a held p2 does not block a fresh p1 edge.
    step(0, 1, 1, CTR, 1, 0, 2'b00, 0, 2'b00, "both_press");
    step(0, 0, 0, CTR, 1, 0, 2'b00, 0, 2'b00, "both_release");
    step(0, 0, 1, oh(3), 1, 0, 2'b00, 0, 2'b00, "p2_move");
    step(0, 1, 1, oh(4), 1, 0, 2'b00, 0, 2'b00, "p1_vs_held_p2");
    step(0, 0, 0, oh(4), 1, 0, 2'b00, 0, 2'b00, "idle");

    // Reset while in the second ROUND_END cycle.
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, oh(4 + k), 1, 0, 2'b00, 0, 2'b00, "p1_move_r2");
      step(0, 0, 0, oh(4 + k), 1, 0, 2'b00, 0, 2'b00, "p1_gap_r2");
    end
    step(0, 1, 0, ZERO, 2, 0, 2'b01, 0, 2'b00, "p1_round_win_r2");
    step(0, 0, 0, ZERO, 2, 0, 2'b00, 0, 2'b00, "round_end_cnt1");
    step(1, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "reset_in_round_end");
    step(0, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "after_reset");

    // Player 2 wins seven rounds and the match.
    for (int r = 1; r <= 7; r++) begin
      for (int k = 1; k <= 4; k++) begin
        step(0, 0, 1, oh(4 - k), 0, 3'(r - 1), 2'b00, 0, 2'b00, "p2_move");
        step(0, 0, 0, oh(4 - k), 0, 3'(r - 1), 2'b00, 0, 2'b00, "p2_gap");
      end
      step(0, 0, 1, ZERO, 0, 3'(r), 2'b10, 0, 2'b00, "p2_round_win");
      repeat (3) step(0, 0, 0, ZERO, 0, 3'(r), 2'b00, 0, 2'b00, "p2_round_hold");
      if (r < 7) step(0, 0, 0, CTR, 0, 3'(r), 2'b00, 0, 2'b00, "p2_next_round");
      else       step(0, 0, 0, ONES, 0, 3'd7, 2'b00, 1, 2'b10, "match_over");
    end
    step(0, 1, 0, ONES, 0, 7, 2'b00, 1, 2'b10, "frozen_p1");
    step(0, 0, 1, ONES, 0, 7, 2'b00, 1, 2'b10, "frozen_p2");
    step(0, 1, 1, ONES, 0, 7, 2'b00, 1, 2'b10, "frozen_both");
    step(0, 0, 0, ONES, 0, 7, 2'b00, 1, 2'b10, "frozen_idle");
    step(1, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "reset_from_match_over");
    step(0, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "after_match_reset");

    // Computer at level 0 never presses; the p2 button is ignored.
    cpu_en    = 1'b1;
    cpu_level = 10'd0;
    step(1, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "reset_cpu");
    for (int i = 0; i < 2000; i++)
      step(0, 0, i[0], CTR, 0, 0, 2'b00, 0, 2'b00, "cpu_level0");

    // Computer at level 512: moves follow rising edges of (lfsr < 512).
    cpu_level = 10'd512;
    step(1, 0, 0, CTR, 0, 0, 2'b00, 0, 2'b00, "reset_cpu512");
    m    = 10'd0;
    prev = 1'b1;
    pr   = 0;
    for (int i = 0; i < 400 && pr < 4; i++) begin
      s    = (m < 10'd512);
      pr   = pr + int'(s & ~prev);
      prev = s;
      m    = {m[8:0], ~(m[9] ^ m[6])};
      step(0, 0, 0, oh(4 - pr), 0, 0, 2'b00, 0, 2'b00, "cpu_level512");
    end
    cpu_en = 1'b0;
    step(0, 0, 0, oh(4 - pr), 0, 0, 2'b00, 0, 2'b00, "cpu_off");

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
